mindfocus_engine: RTL
=====================

MINDFOCUS_ENGINE -- requirements
Module: mindfocus_engine

Interface
REQ-001 Parameter N_BOTOES, default 4: number of buttons and image indices; SHALL be a power of two, 2..16.
REQ-002 Parameter PROFUNDIDADE, default 16: maximum sequence length, i.e. the final round; SHALL be 2..64.
REQ-003 Parameter T_IMG, default 1000: display cycles per sequence item; SHALL be >= 1.
REQ-004 Parameter T_JOGADA, default 5000: per-play timeout in cycles; SHALL be >= 2.
REQ-005 Derived widths: IW = log2(N_BOTOES); AW = clog2(PROFUNDIDADE+1).
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clock  in  1  system clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 iniciar  in  1  start or restart request; level sampled each cycle.
REQ-010 voltar  in  1  abort to IDLE.
REQ-011 modo  in  1  play order: 0 = same order as displayed, 1 = reverse order; latched on start.
REQ-012 botoes  in  N_BOTOES  button levels, one bit per index.
REQ-013 indice  out  IW  index of the image currently displayed.
REQ-014 mostra  out  1  indice is valid for display.
REQ-015 espera_jogada  out  1  high while awaiting a button play.
REQ-016 pronto  out  1  game over, either won or lost.
REQ-017 ganhou / perdeu  out  1 each  game outcome flags.
REQ-018 acertos  out  AW  number of completed rounds.
REQ-019 rodada  out  AW  current round number r, 1..PROFUNDIDADE; 0 in IDLE.
REQ-020 db_estado  out  4  state code.

Function
REQ-021 States and codes: IDLE=0, GERA=1, MOSTRA=2, ESPERA=3, COMPARA=4, PROX=5, GANHOU=6, PERDEU=7.
REQ-022 LFSR: 16-bit, polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances every cycle, never reaches zero.
REQ-023 IDLE or GANHOU or PERDEU with iniciar=1: clear acertos, set r=1, latch modo, and go to GERA on the next cycle.
REQ-024 GERA (1 cycle): write the low IW bits of the LFSR into mem[r-1], set k=0, go to MOSTRA; entries 0..r-2 are kept.
REQ-025 MOSTRA: for k = 0..r-1, drive indice=mem[k] with mostra=1 for T_IMG cycles, then one blank cycle with mostra=0.
REQ-026 MOSTRA completion: after the blank cycle of item r-1, go to ESPERA with k=0 and the timer cleared.
REQ-027 Play detection: a play is a registered transition of botoes from all-zero to nonzero. Buttons already held on entry to ESPERA do not count until released.
REQ-028 ESPERA: espera_jogada=1 and the timer increments. A play goes to COMPARA with the botoes value captured. Timer reaching T_JOGADA-1 with no play goes to PERDEU.
REQ-029 COMPARA (1 cycle): the expected index is mem[k] if modo=0, mem[r-1-k] if modo=1. The play is correct only if exactly one bit is set and its position equals the expected index.
REQ-030 COMPARA outcomes: correct with k<r-1 -> k+1, timer cleared, back to ESPERA. Correct with k=r-1 -> PROX. Incorrect (including multi-bit) -> PERDEU.
REQ-031 PROX (1 cycle): acertos+1. If r=PROFUNDIDADE go to GANHOU, else r+1 and go to GERA.
REQ-032 GANHOU and PERDEU hold pronto=1 and the matching flag, with acertos and rodada frozen, until iniciar or voltar.
REQ-033 voltar=1 in any state forces IDLE on the next edge; voltar has priority over iniciar and over all other transitions.
REQ-034 In IDLE all outputs are zero, except that the LFSR keeps running.
REQ-035 indice is 0 whenever mostra=0.

Reset
REQ-036 reset=1 immediately sets: state IDLE, all counters and outputs 0, LFSR to 16'hACE1. mem contents are don't-care.
REQ-037 Reset asserted mid-game aborts the game with no residual outputs after release.

Verification (N_BOTOES=4, PROFUNDIDADE=3, T_IMG=4, T_JOGADA=20)
REQ-038 Reset pulse -> db_estado=0; mostra, pronto, ganhou, perdeu, acertos and rodada all 0.
REQ-039 iniciar with modo=0, bench echoes every displayed item one-hot in order -> mostra high pulses of 4 cycles, 1/2/3 items per round; ganhou=1, pronto=1, acertos=3, db_estado=6.
REQ-040 modo=1 with the plays entered in reverse -> win as in REQ-039. Same sequence entered in forward order, with mem[0]!=mem[r-1] -> perdeu=1 on the first play.
REQ-041 No press for 20 cycles in round 1 ESPERA -> perdeu=1, acertos=0, db_estado=7.
REQ-042 botoes=4'b0011 pressed in ESPERA -> perdeu=1.
REQ-043 voltar during MOSTRA -> IDLE on the next cycle with mostra=0. Async reset asserted during ESPERA -> IDLE with no clock edge.

Source files
------------

// File: rtl/mindfocus_engine.sv
// Memory game: shows a growing pseudo-random sequence of image indices and
// checks the button plays against it, in forward or reverse order.
module mindfocus_engine #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int T_IMG        = 1000,
  parameter int T_JOGADA     = 5000,
  localparam int IW          = $clog2(N_BOTOES),
  localparam int AW          = $clog2(PROFUNDIDADE + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                voltar,
  input  logic                modo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [IW-1:0]       indice,
  output logic                mostra,
  output logic                espera_jogada,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic [AW-1:0]       acertos,
  output logic [AW-1:0]       rodada,
  output logic [3:0]          db_estado
);

  localparam int MW   = $clog2(PROFUNDIDADE);
  localparam int TMAX = (T_IMG > T_JOGADA) ? T_IMG : T_JOGADA;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GERA    = 4'd1,
    S_MOSTRA  = 4'd2,
    S_ESPERA  = 4'd3,
    S_COMPARA = 4'd4,
    S_PROX    = 4'd5,
    S_GANHOU  = 4'd6,
    S_PERDEU  = 4'd7
  } state_t;

  state_t                state_q;
  logic [15:0]           lfsr_q;
  logic [15:0]           lfsr_d;
  logic [AW-1:0]         r_q;
  logic [AW-1:0]         k_q;
  logic [AW-1:0]         acertos_q;
  logic                  modo_q;
  logic [TW-1:0]         timer_q;
  logic [N_BOTOES-1:0]   btn_q;
  logic [N_BOTOES-1:0]   btn_prev_q;
  logic [N_BOTOES-1:0]   cap_q;
  logic [IW-1:0]         mem_q [PROFUNDIDADE];

  logic [MW-1:0]         k_idx;
  logic [MW-1:0]         gen_idx;
  logic [MW-1:0]         rev_idx;
  logic [IW-1:0]         exp_idx;
  logic                  correct;
  logic                  play;
  logic                  last_item;

  // Fibonacci form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign k_idx     = MW'(k_q);
  assign gen_idx   = MW'(r_q - AW'(1));
  assign rev_idx   = MW'(r_q - k_q - AW'(1));
  assign exp_idx   = modo_q ? mem_q[rev_idx] : mem_q[k_idx];
  assign correct   = (cap_q == (N_BOTOES'(1) << exp_idx));
  assign last_item = (k_q == r_q - AW'(1));

  // A play is the registered edge from all-released to any button held, so a
  // button already down when ESPERA starts has to be released first.
  assign play = (btn_prev_q == '0) && (btn_q != '0);

  assign mostra        = (state_q == S_MOSTRA) && (timer_q < TW'(T_IMG));
  assign indice        = mostra ? mem_q[k_idx] : '0;
  assign espera_jogada = (state_q == S_ESPERA);
  assign ganhou        = (state_q == S_GANHOU);
  assign perdeu        = (state_q == S_PERDEU);
  assign pronto        = ganhou | perdeu;
  assign acertos       = acertos_q;
  assign rodada        = r_q;
  assign db_estado     = state_q;

  always_ff @(posedge clock) begin
    if (state_q == S_GERA) mem_q[gen_idx] <= lfsr_q[IW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 16'hACE1;
      r_q        <= '0;
      k_q        <= '0;
      acertos_q  <= '0;
      modo_q     <= 1'b0;
      timer_q    <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      cap_q      <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      btn_q      <= botoes;
      btn_prev_q <= btn_q;
      if (voltar) begin
        state_q   <= S_IDLE;
        r_q       <= '0;
        k_q       <= '0;
        acertos_q <= '0;
        modo_q    <= 1'b0;
        timer_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_GANHOU, S_PERDEU: begin
            if (iniciar) begin
              acertos_q <= '0;
              r_q       <= AW'(1);
              k_q       <= '0;
              timer_q   <= '0;
              modo_q    <= modo;
              state_q   <= S_GERA;
            end
          end
          S_GERA: begin
            k_q     <= '0;
            timer_q <= '0;
            state_q <= S_MOSTRA;
          end
          S_MOSTRA: begin
            // timer == T_IMG is the blank cycle that separates items
            if (timer_q == TW'(T_IMG)) begin
              timer_q <= '0;
              if (last_item) begin
                k_q     <= '0;
                state_q <= S_ESPERA;
              end else begin
                k_q <= k_q + AW'(1);
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_ESPERA: begin
            if (play) begin
              cap_q   <= btn_q;
              state_q <= S_COMPARA;
            end else if (timer_q == TW'(T_JOGADA - 1)) begin
              state_q <= S_PERDEU;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_COMPARA: begin
            if (!correct) begin
              state_q <= S_PERDEU;
            end else if (last_item) begin
              state_q <= S_PROX;
            end else begin
              k_q     <= k_q + AW'(1);
              timer_q <= '0;
              state_q <= S_ESPERA;
            end
          end
          S_PROX: begin
            acertos_q <= acertos_q + AW'(1);
            if (r_q == AW'(PROFUNDIDADE)) begin
              state_q <= S_GANHOU;
            end else begin
              r_q     <= r_q + AW'(1);
              state_q <= S_GERA;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
